// File: rtl/sram_rw_param_ext_if.sv
// Request/response bundle for the single-port masked SRAM.
// The master drives address, enable, mode, mask and write data.
// The slave (the SRAM) returns read data, the read-valid pulse and ready.
interface sram_rw_param_ext_if #(
  parameter int DATA_WIDTH = 256,
  parameter int ADDR_WIDTH = 9,
  parameter int MASK_GRAN  = 8
);
  localparam int MASK_WIDTH = DATA_WIDTH / MASK_GRAN;

  logic [ADDR_WIDTH-1:0] RW0_addr;
  logic                  RW0_en;
  logic                  RW0_wmode;
  logic [MASK_WIDTH-1:0] RW0_wmask;
  logic [DATA_WIDTH-1:0] RW0_wdata;
  logic [DATA_WIDTH-1:0] RW0_rdata;
  logic                  RW0_rvalid;
  logic                  RW0_ready;

  modport master (
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    input  RW0_rdata, RW0_rvalid, RW0_ready
  );

  modport slave (
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata,
    output RW0_rdata, RW0_rvalid, RW0_ready
  );
endinterface

// File: rtl/sram_rw_param_ext.sv
// Single-port SRAM with per-lane write mask and a 1- or 2-cycle read pipeline.
// Out-of-range addresses are ignored on write and read back as zero.
// Optional build macro SRAM_INIT_SWEEP_EN: after reset release, zero every word
// (one per cycle) before raising ready. Without it, ready rises on the first
// clock edge after reset release and memory starts undefined.
// The interface instance must be built with the same DATA_WIDTH, ADDR_WIDTH
// and MASK_GRAN as this module.
module sram_rw_param_ext #(
  parameter int DATA_WIDTH   = 256,
  parameter int DEPTH        = 512,
  parameter int ADDR_WIDTH   = 9,
  parameter int MASK_GRAN    = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic               RW0_clk,
  input  logic               RW0_reset,
  sram_rw_param_ext_if.slave rw0
);
  localparam int MASK_WIDTH = DATA_WIDTH / MASK_GRAN;
  localparam int IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  ready_q;
  logic                  in_range;
  logic [IDX_W-1:0]      idx;
  logic                  acc_rd;
  logic                  acc_wr;
  logic [DATA_WIDTH-1:0] rd_word_d;

  logic                  wr_en_d;
  logic [IDX_W-1:0]      wr_idx_d;
  logic [MASK_WIDTH-1:0] wr_lanes_d;
  logic [DATA_WIDTH-1:0] wr_word_d;

  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  rvalid_q;

  assign in_range = {1'b0, rw0.RW0_addr} < DEPTH_EXT;
  assign idx      = rw0.RW0_addr[IDX_W-1:0];
  assign acc_rd   = rw0.RW0_en && ready_q && !rw0.RW0_wmode;
  assign acc_wr   = rw0.RW0_en && ready_q &&  rw0.RW0_wmode;

  // Out-of-range reads return zero; the array index is only trusted in range.
  assign rd_word_d = in_range ? mem[idx] : '0;

`ifdef SRAM_INIT_SWEEP_EN
  typedef enum logic {ST_INIT, ST_READY} state_t;

  state_t           state_q;
  logic [IDX_W-1:0] sweep_q;
  logic             sweeping;

  // Init/ready FSM: any reset restarts the zeroing sweep from address 0.
  always_ff @(posedge RW0_clk or posedge RW0_reset) begin
    if (RW0_reset) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          if (sweep_q == IDX_W'(DEPTH - 1)) begin
            state_q <= ST_READY;
            ready_q <= 1'b1;
          end else begin
            sweep_q <= sweep_q + IDX_W'(1);
          end
        end
        default: ready_q <= 1'b1;
      endcase
    end
  end

  // Memory is only touched by the sweep once reset has been released.
  assign sweeping   = (state_q == ST_INIT) && !RW0_reset;
  assign wr_en_d    = sweeping || (acc_wr && in_range);
  assign wr_idx_d   = sweeping ? sweep_q : idx;
  assign wr_lanes_d = sweeping ? '1 : rw0.RW0_wmask;
  assign wr_word_d  = sweeping ? '0 : rw0.RW0_wdata;
`else
  // Ready comes up on the first clock edge after reset release.
  always_ff @(posedge RW0_clk or posedge RW0_reset) begin
    if (RW0_reset) ready_q <= 1'b0;
    else           ready_q <= 1'b1;
  end

  assign wr_en_d    = acc_wr && in_range;
  assign wr_idx_d   = idx;
  assign wr_lanes_d = rw0.RW0_wmask;
  assign wr_word_d  = rw0.RW0_wdata;
`endif

  // Lane-masked write port; no reset so the array maps onto byte-enabled RAM.
  always_ff @(posedge RW0_clk) begin
    if (wr_en_d) begin
      for (int k = 0; k < MASK_WIDTH; k++) begin
        if (wr_lanes_d[k]) begin
          mem[wr_idx_d][k*MASK_GRAN +: MASK_GRAN] <= wr_word_d[k*MASK_GRAN +: MASK_GRAN];
        end
      end
    end
  end

  generate
    if (READ_LATENCY == 2) begin : g_lat2
      logic [DATA_WIDTH-1:0] s1_data_q;
      logic                  s1_valid_q;

      // Two-stage read pipeline; data is snapshotted at accept so later writes cannot disturb it.
      always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
          s1_data_q  <= '0;
          s1_valid_q <= 1'b0;
          rdata_q    <= '0;
          rvalid_q   <= 1'b0;
        end else begin
          s1_valid_q <= acc_rd;
          if (acc_rd) s1_data_q <= rd_word_d;
          rvalid_q <= s1_valid_q;
          if (s1_valid_q) rdata_q <= s1_data_q;
        end
      end
    end else begin : g_lat1
      // Single-stage read; rdata only moves when a read completes.
      always_ff @(posedge RW0_clk or posedge RW0_reset) begin
        if (RW0_reset) begin
          rdata_q  <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= acc_rd;
          if (acc_rd) rdata_q <= rd_word_d;
        end
      end
    end
  endgenerate

  assign rw0.RW0_rdata  = rdata_q;
  assign rw0.RW0_rvalid = rvalid_q;
  assign rw0.RW0_ready  = ready_q;
endmodule
